rlbp_seq_ctrl: RTL

//  Sequencer for the rlbp core. Accepts a 9-pixel window as a valid/ready stream and shifts it

---
 rtl/rlbp_pkg.sv | 17 +
 rtl/rlbp_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rlbp_pkg.sv
// Shared types and constants for the rlbp sequencer.
package rlbp_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, OUT} state_t;

  localparam int WIN_PIX = 9;  // pixels per window
  localparam int ROWS    = 3;  // delay chains in the core
  localparam int NSEL    = 4;  // data_out nibbles per result

  // Delay-chain enable for window pixel k: three consecutive pixels per row.
  function automatic logic [ROWS-1:0] row_ce(input logic [3:0] k);
    if (k < 4'(WIN_PIX / ROWS))          row_ce = 3'b001;
    else if (k < 4'(2 * WIN_PIX / ROWS)) row_ce = 3'b010;
    else                                 row_ce = 3'b100;
  endfunction

endpackage

// File: rtl/rlbp_seq_ctrl.sv
// Sequencer for the rlbp core: loads a 9-pixel window, starts the core,
// waits for done with a timeout, then collects four data_out nibbles.
module rlbp_seq_ctrl
  import rlbp_pkg::*;
#(
  parameter int PIX_W  = 4,
  parameter int TMO_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               abort,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  output logic [PIX_W-1:0]   rlbp_d,
  output logic [2:0]         rlbp_ce,
  output logic               rlbp_start,
  input  logic               rlbp_done,
  output logic [1:0]         rlbp_sel,
  input  logic [PIX_W-1:0]   rlbp_dout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [4*PIX_W-1:0] res_data,
  output logic               busy,
  output logic               tmo_err
);

  // Timeout fires on the cycle whose increment would reach 2**TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [1:0]       SET_LAST = 2'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       pix_cnt;
  logic [1:0]       sel_cnt;
  logic [1:0]       set_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic hs, last_pix, tmo_hit, step_done, rd_last;

  assign hs        = pix_valid & pix_ready;
  assign last_pix  = hs && (pix_cnt == 4'(WIN_PIX - 1));
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign step_done = (set_cnt == SET_LAST);
  assign rd_last   = step_done && (sel_cnt == 2'(NSEL - 1));

  assign rlbp_sel  = sel_cnt;
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = LOAD;
      LOAD:    if (last_pix) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (rlbp_done) state_d = READ;
               else if (tmo_hit) state_d = IDLE;
      READ:    if (rd_last) state_d = OUT;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Counters and registered outputs; ce/start are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_ready  <= 1'b0;
      rlbp_d     <= '0;
      rlbp_ce    <= '0;
      rlbp_start <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      tmo_err    <= 1'b0;
      pix_cnt    <= '0;
      sel_cnt    <= '0;
      set_cnt    <= '0;
      tmo_cnt    <= '0;
    end else begin
      rlbp_ce    <= '0;
      rlbp_start <= 1'b0;
      if (abort) begin
        pix_ready <= 1'b0;
        res_valid <= 1'b0;
        pix_cnt   <= '0;
        sel_cnt   <= '0;
        set_cnt   <= '0;
        tmo_cnt   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            pix_cnt <= '0;
            if (enable) pix_ready <= 1'b1;
          end
          LOAD: if (hs) begin
            rlbp_d  <= pix_data;
            rlbp_ce <= row_ce(pix_cnt);
            pix_cnt <= pix_cnt + 4'd1;
            if (pix_cnt == 4'd0) tmo_err <= 1'b0;
            if (last_pix) begin
              pix_ready <= 1'b0;
              pix_cnt   <= '0;
            end
          end
          START: begin
            rlbp_start <= 1'b1;
            tmo_cnt    <= '0;
          end
          WAIT: begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
            if (rlbp_done) begin
              sel_cnt <= '0;
              set_cnt <= '0;
            end else if (tmo_hit) begin
              tmo_err <= 1'b1;
            end
          end
          READ: begin
            if (step_done) begin
              res_data[int'(sel_cnt)*PIX_W +: PIX_W] <= rlbp_dout;
              set_cnt <= '0;
              if (rd_last) res_valid <= 1'b1;
              else         sel_cnt   <= sel_cnt + 2'd1;
            end else begin
              set_cnt <= set_cnt + 2'd1;
            end
          end
          OUT: if (res_ready) res_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
